// File: rtl/step_seq_gen_if.sv
// Step sequencer control/status bundle.
//   master: drives start, mode_loop, hold, abort; observes the sequencer status.
//   slave : the sequencer itself; samples the controls, drives c1, i, x, y,
//           act1, act2, busy, done.
interface step_seq_gen_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSTEP = 4,
  parameter int unsigned IW    = 2
);

  // Controls
  logic             start;
  logic             mode_loop;
  logic             hold;
  logic             abort;

  // Status
  logic [WIDTH-1:0] c1;
  logic [IW-1:0]    i;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [NSTEP-1:0] act1;
  logic             act2;
  logic             busy;
  logic             done;

  modport master (
    output start, mode_loop, hold, abort,
    input  c1, i, x, y, act1, act2, busy, done
  );

  modport slave (
    input  start, mode_loop, hold, abort,
    output c1, i, x, y, act1, act2, busy, done
  );

endinterface

// File: rtl/step_seq_gen.sv
// Parametrised step sequencer: walks step index i through NSTEP steps of DWELL
// clocks each, accumulating x (steps completed) and y (sum of i+1 over completed
// steps) at every step boundary. One-shot or loop mode, hold and abort.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : step_seq_gen_if.slave
//           in  start, mode_loop, hold, abort
//           out c1, i, x, y, act1 (one-hot of i while busy), act2 (boundary
//               strobe), busy, done (end-of-one-shot strobe); all registered
module step_seq_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSTEP = 4,
  parameter int unsigned IW    = 2,
  parameter int unsigned DWELL = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  step_seq_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] C1_LAST  = WIDTH'(DWELL - 1);
  localparam logic [IW-1:0]    I_LAST   = IW'(NSTEP - 1);
  localparam logic [NSTEP-1:0] ACT1_FST = NSTEP'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] c1_q, c1_d;
  logic [IW-1:0]    i_q, i_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [NSTEP-1:0] act1_q, act1_d;
  logic             act2_q, act2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             loop_q, loop_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c1_q    <= '0;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      act1_q  <= '0;
      act2_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c1_q    <= c1_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      act1_q  <= act1_d;
      act2_q  <= act2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      loop_q  <= loop_d;
    end
  end

  // Next-state and next-output logic; strobes default low, everything else holds
  always_comb begin
    state_d = state_q;
    c1_d    = c1_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    act1_d  = act1_q;
    act2_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    loop_d  = loop_q;

    case (state_q)
      ST_IDLE: begin
        // start beats a simultaneous abort here; x/y restart from zero
        if (bus.start) begin
          state_d = ST_RUN;
          c1_d    = '0;
          i_d     = '0;
          x_d     = '0;
          y_d     = '0;
          loop_d  = bus.mode_loop;
          busy_d  = 1'b1;
          act1_d  = ACT1_FST;
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          // x/y keep their partial totals for inspection
          state_d = ST_IDLE;
          c1_d    = '0;
          i_d     = '0;
          busy_d  = 1'b0;
          act1_d  = '0;
        end else if (!bus.hold) begin
          if (c1_q != C1_LAST) begin
            c1_d = c1_q + WIDTH'(1);
          end else begin
            // Step boundary: y accumulates the 1-based number of the step just finished
            c1_d   = '0;
            x_d    = x_q + WIDTH'(1);
            y_d    = y_q + WIDTH'(i_q) + WIDTH'(1);
            act2_d = 1'b1;
            if (i_q != I_LAST) begin
              i_d    = i_q + IW'(1);
              act1_d = act1_q << 1;
            end else if (loop_q) begin
              i_d    = '0;
              act1_d = ACT1_FST;
            end else begin
              state_d = ST_IDLE;
              i_d     = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              act1_d  = '0;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.c1   = c1_q;
  assign bus.i    = i_q;
  assign bus.x    = x_q;
  assign bus.y    = y_q;
  assign bus.act1 = act1_q;
  assign bus.act2 = act2_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_step_seq_gen.sv
// Testbench for step_seq_gen: directed scenarios plus a randomized run checked
// against a model that derives every output from the count of non-held RUN clocks.
module tb_step_seq_gen;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned D  = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  step_seq_gen_if #(.WIDTH(W), .NSTEP(N), .IW(IW)) if0 ();
  step_seq_gen_if #(.WIDTH(4), .NSTEP(4), .IW(2))  if1 ();

  step_seq_gen #(.WIDTH(W), .NSTEP(N), .IW(IW), .DWELL(D)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  step_seq_gen #(.WIDTH(4), .NSTEP(4), .IW(2), .DWELL(2)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int y_of(int k);
    int f;
    int r;
    f = k / N;
    r = k % N;
    return f * (N * (N + 1) / 2) + r * (r + 1) / 2;
  endfunction

  task automatic test_reset();
    logic [32:0] got0;
    logic [20:0] got1;
    rst_n = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    got0 = {if0.c1, if0.i, if0.x, if0.y, if0.act1, if0.act2, if0.busy, if0.done};
    got1 = {if1.c1, if1.i, if1.x, if1.y, if1.act1, if1.act2, if1.busy, if1.done};
    n_tests++;
    if (got0 !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", got0);
    end
    n_tests++;
    if (got1 !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_w4: got %h expected 0", got1);
    end
    rst_n = 1'b1;
    cycle();
    cycle();
    got0 = {if0.c1, if0.i, if0.x, if0.y, if0.act1, if0.act2, if0.busy, if0.done};
    n_tests++;
    if (got0 !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected 0", got0);
    end
  endtask

  task automatic test_oneshot();
    logic [6:0] got;
    logic [6:0] exp;
    if0.mode_loop = 1'b0;
    if0.start = 1'b1;
    cycle();
    if0.start = 1'b0;
    n_tests++;
    if ({if0.busy, if0.act1, if0.c1, if0.x, if0.y} !== {1'b1, 4'b0001, 8'd0, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL oneshot_entry: got busy=%b act1=%b c1=%0d x=%0d y=%0d expected 1 0001 0 0 0",
               if0.busy, if0.act1, if0.c1, if0.x, if0.y);
    end
    for (int e = 1; e <= 40; e++) begin
      cycle();
      exp[6]   = (e % 10 == 0);
      exp[5]   = (e == 40);
      exp[4]   = (e < 40);
      exp[3:0] = (e < 40) ? 4'(1 << (e / 10)) : 4'd0;
      got = {if0.act2, if0.done, if0.busy, if0.act1};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL oneshot_edge%0d: got act2/done/busy/act1=%b expected %b", e, got, exp);
      end
    end
    n_tests++;
    if ({if0.x, if0.y} !== {8'd4, 8'd10}) begin
      n_fail++;
      $display("FAIL oneshot_final: got x=%0d y=%0d expected x=4 y=10", if0.x, if0.y);
    end
    cycle();
    n_tests++;
    if ({if0.done, if0.busy, if0.x, if0.y} !== {1'b0, 1'b0, 8'd4, 8'd10}) begin
      n_fail++;
      $display("FAIL oneshot_idle_hold: got done=%b busy=%b x=%0d y=%0d expected 0 0 4 10",
               if0.done, if0.busy, if0.x, if0.y);
    end
  endtask

  task automatic test_loop();
    int wraps = 0;
    bit saw_done = 1'b0;
    logic [IW-1:0] prev_i;
    if0.mode_loop = 1'b1;
    if0.start = 1'b1;
    cycle();
    if0.start = 1'b0;
    if0.mode_loop = 1'b0;
    prev_i = if0.i;
    repeat (80) begin
      cycle();
      if (prev_i == 2'd3 && if0.i == 2'd0 && if0.busy) wraps++;
      if (if0.done) saw_done = 1'b1;
      prev_i = if0.i;
    end
    n_tests++;
    if ({if0.x, if0.y, if0.busy} !== {8'd8, 8'd20, 1'b1}) begin
      n_fail++;
      $display("FAIL loop_totals: got x=%0d y=%0d busy=%b expected 8 20 1", if0.x, if0.y, if0.busy);
    end
    n_tests++;
    if (wraps != 2 || saw_done) begin
      n_fail++;
      $display("FAIL loop_wraps: got wraps=%0d done_seen=%b expected 2 0", wraps, saw_done);
    end
    if0.abort = 1'b1;
    cycle();
    if0.abort = 1'b0;
    n_tests++;
    if ({if0.busy, if0.done, if0.x, if0.y} !== {1'b0, 1'b0, 8'd8, 8'd20}) begin
      n_fail++;
      $display("FAIL loop_abort: got busy=%b done=%b x=%0d y=%0d expected 0 0 8 20",
               if0.busy, if0.done, if0.x, if0.y);
    end
  endtask

  task automatic test_hold();
    int e;
    bit found = 1'b0;
    if0.mode_loop = 1'b0;
    if0.start = 1'b1;
    cycle();
    if0.start = 1'b0;
    repeat (13) cycle();
    n_tests++;
    if ({if0.i, if0.c1} !== {2'd1, 8'd3}) begin
      n_fail++;
      $display("FAIL hold_pre: got i=%0d c1=%0d expected 1 3", if0.i, if0.c1);
    end
    if0.hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_tests++;
      if ({if0.c1, if0.i, if0.x, if0.y, if0.act2} !== {8'd3, 2'd1, 8'd1, 8'd1, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_frozen%0d: got c1=%0d i=%0d x=%0d y=%0d act2=%b expected 3 1 1 1 0",
                 k, if0.c1, if0.i, if0.x, if0.y, if0.act2);
      end
    end
    if0.hold = 1'b0;
    e = 18;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      e++;
      if (if0.act2) found = 1'b1;
    end
    n_tests++;
    if (!found || e != 25 || if0.x !== 8'd2) begin
      n_fail++;
      $display("FAIL hold_boundary: got edge=%0d found=%b x=%0d expected edge 25 x=2", e, found, if0.x);
    end
    if0.abort = 1'b1;
    cycle();
    if0.abort = 1'b0;
  endtask

  task automatic test_abort();
    if0.mode_loop = 1'b0;
    if0.start = 1'b1;
    cycle();
    if0.start = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      if (e == 5) if0.start = 1'b1;
      cycle();
      if0.start = 1'b0;
      if (e == 5) begin
        n_tests++;
        if ({if0.c1, if0.busy} !== {8'd5, 1'b1}) begin
          n_fail++;
          $display("FAIL abort_start_ignored: got c1=%0d busy=%b expected 5 1", if0.c1, if0.busy);
        end
      end
    end
    n_tests++;
    if ({if0.i, if0.c1} !== {2'd2, 8'd4}) begin
      n_fail++;
      $display("FAIL abort_pre: got i=%0d c1=%0d expected 2 4", if0.i, if0.c1);
    end
    if0.abort = 1'b1;
    cycle();
    if0.abort = 1'b0;
    n_tests++;
    if ({if0.busy, if0.c1, if0.i, if0.x, if0.y, if0.done, if0.act2, if0.act1}
        !== {1'b0, 8'd0, 2'd0, 8'd2, 8'd3, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL abort_post: got busy=%b c1=%0d i=%0d x=%0d y=%0d done=%b act2=%b act1=%b expected 0 0 0 2 3 0 0 0000",
               if0.busy, if0.c1, if0.i, if0.x, if0.y, if0.done, if0.act2, if0.act1);
    end
  endtask

  task automatic test_async_reset();
    logic [32:0] got;
    if0.mode_loop = 1'b0;
    if0.start = 1'b1;
    cycle();
    if0.start = 1'b0;
    repeat (15) cycle();
    n_tests++;
    if ({if0.i, if0.busy} !== {2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL async_pre: got i=%0d busy=%b expected 1 1", if0.i, if0.busy);
    end
    #1 rst_n = 1'b0;
    #1;
    got = {if0.c1, if0.i, if0.x, if0.y, if0.act1, if0.act2, if0.busy, if0.done};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", got);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_width4_wrap();
    if1.mode_loop = 1'b1;
    if1.start = 1'b1;
    cycle();
    if1.start = 1'b0;
    if1.mode_loop = 1'b0;
    repeat (80) cycle();
    n_tests++;
    if ({if1.x, if1.y, if1.i, if1.busy} !== {4'd8, 4'd4, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL w4_wrap: got x=%0d y=%0d i=%0d busy=%b expected 8 4 0 1",
               if1.x, if1.y, if1.i, if1.busy);
    end
    if1.abort = 1'b1;
    cycle();
    if1.abort = 1'b0;
  endtask

  task automatic test_random();
    bit m_run = 1'b0;
    bit m_loop = 1'b0;
    int m_t = 0;
    bit m_a2;
    bit m_dn;
    bit s, md, h, ab;
    int k;
    int ei;
    logic [32:0] exp;
    logic [32:0] got;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      s  = ($urandom_range(7) == 0);
      md = 1'($urandom_range(1));
      h  = ($urandom_range(3) == 0);
      ab = ($urandom_range(31) == 0);
      if0.start = s;
      if0.mode_loop = md;
      if0.hold = h;
      if0.abort = ab;
      cycle();
      m_a2 = 1'b0;
      m_dn = 1'b0;
      if (!m_run) begin
        if (s) begin
          m_run = 1'b1;
          m_loop = md;
          m_t = 0;
        end
      end else if (ab) begin
        m_run = 1'b0;
      end else if (!h) begin
        m_t++;
        if (m_t % D == 0) begin
          m_a2 = 1'b1;
          if (!m_loop && m_t / D == N) begin
            m_run = 1'b0;
            m_dn = 1'b1;
          end
        end
      end
      k  = m_t / D;
      ei = m_run ? k % N : 0;
      exp = {(m_run ? 8'(m_t % D) : 8'd0), 2'(ei), 8'(k), 8'(y_of(k)),
             (m_run ? 4'(1 << ei) : 4'd0), m_a2, m_run, m_dn};
      got = {if0.c1, if0.i, if0.x, if0.y, if0.act1, if0.act2, if0.busy, if0.done};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got {c1,i,x,y,act1,act2,busy,done}=%h expected %h", n, got, exp);
      end
    end
    if0.start = 1'b0;
    if0.hold = 1'b0;
    if0.abort = 1'b0;
    if0.mode_loop = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    if0.start = 1'b0;
    if0.mode_loop = 1'b0;
    if0.hold = 1'b0;
    if0.abort = 1'b0;
    if1.start = 1'b0;
    if1.mode_loop = 1'b0;
    if1.hold = 1'b0;
    if1.abort = 1'b0;
    test_reset();
    test_oneshot();
    test_loop();
    test_hold();
    test_abort();
    test_async_reset();
    test_width4_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
